lcd_spi_byte_writer: RTL and testbench

Serial back end of the ST7735 LCD path. Accepts the 9-bit command/data words produced by the drawing-data organisers (character, number and fill blocks) under a level `en_write` handshake. Shifts each byte out MSB-first on a 4-wire SPI link (mode 0) with the D/C line taken from bit 8. Returns a one-cycle `wr_done` per byte, which the organisers use to advance to their next word.

---
 rtl/lcd_spi_byte_writer_if.sv | 22 ++
 rtl/lcd_spi_byte_writer.sv | 100 ++++++++++
 tb/tb_lcd_spi_byte_writer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_byte_writer_if.sv
// Word handshake and SPI pins between the drawing-data organisers, the
// serial back end and the ST7735 panel.
interface lcd_spi_byte_writer_if;
    logic       en_write;
    logic [8:0] data_in;
    logic       wr_done;
    logic       busy;
    logic       lcd_sclk;
    logic       lcd_mosi;
    logic       lcd_dc;
    logic       lcd_cs_n;

    modport master (
        output en_write, data_in,
        input  wr_done, busy, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n
    );

    modport slave (
        input  en_write, data_in,
        output wr_done, busy, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n
    );
endinterface

// File: rtl/lcd_spi_byte_writer.sv
// SPI mode-0 byte shifter for the ST7735: samples one 9-bit D/C+byte word in
// IDLE, shifts it MSB-first, pulses wr_done, then holds CS high for a gap.
module lcd_spi_byte_writer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    lcd_spi_byte_writer_if.slave  bus
);
    localparam int              DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

    state_t           state_q;
    logic [7:0]       shiftReg_q;
    logic [DIV_W-1:0] divCnt_q;
    logic [2:0]       bitCnt_q;
    logic [3:0]       gapCnt_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             dc_q;
    logic             csN_q;
    logic             wrDone_q;
    logic             busy_q;

    // The falling SCLK edge advances MOSI, so data is always stable across the rise.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            divCnt_q   <= '0;
            bitCnt_q   <= '0;
            gapCnt_q   <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            dc_q       <= 1'b0;
            csN_q      <= 1'b1;
            wrDone_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wrDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en_write) begin
                        shiftReg_q <= bus.data_in[7:0];
                        dc_q       <= bus.data_in[8];
                        mosi_q     <= bus.data_in[7];
                        csN_q      <= 1'b0;
                        divCnt_q   <= '0;
                        bitCnt_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (divCnt_q == DIV_LAST) begin
                        divCnt_q <= '0;
                        sclk_q   <= ~sclk_q;
                        if (sclk_q) begin
                            if (bitCnt_q == 3'd7) begin
                                wrDone_q <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                shiftReg_q <= {shiftReg_q[6:0], 1'b0};
                                mosi_q     <= shiftReg_q[6];
                                bitCnt_q   <= bitCnt_q + 3'd1;
                            end
                        end
                    end else begin
                        divCnt_q <= divCnt_q + DIV_W'(1);
                    end
                end
                DONE: begin
                    csN_q    <= 1'b1;
                    gapCnt_q <= '0;
                    state_q  <= GAP;
                end
                GAP: begin
                    if (gapCnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_done  = wrDone_q;
    assign bus.busy     = busy_q;
    assign bus.lcd_sclk = sclk_q;
    assign bus.lcd_mosi = mosi_q;
    assign bus.lcd_dc   = dc_q;
    assign bus.lcd_cs_n = csN_q;
endmodule

// File: tb/tb_lcd_spi_byte_writer.sv
// Randomized bench for lcd_spi_byte_writer: a pin-level monitor decodes each
// SPI frame and a word-level model supplies the expected byte, D/C and timing.
module tb_lcd_spi_byte_writer;
    logic       sysClk = 1'b0;
    logic       sysRst;
    logic       en;
    logic [8:0] dataIn;
    logic       selB;
    int         curDiv;
    int         curGap;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    always #5 sysClk = ~sysClk;
    always @(posedge sysClk) cyc <= cyc + 1;

    lcd_spi_byte_writer_if ifA ();
    lcd_spi_byte_writer_if ifB ();

    assign ifA.en_write = en & ~selB;
    assign ifB.en_write = en & selB;
    assign ifA.data_in  = dataIn;
    assign ifB.data_in  = dataIn;

    lcd_spi_byte_writer #(.CLK_DIV(2), .GAP_CYCLES(3)) dutA (
        .sys_clk (sysClk),
        .sys_rst (sysRst),
        .bus     (ifA)
    );

    lcd_spi_byte_writer #(.CLK_DIV(1), .GAP_CYCLES(1)) dutB (
        .sys_clk (sysClk),
        .sys_rst (sysRst),
        .bus     (ifB)
    );

    logic oSclk, oMosi, oDc, oCsN, oWr, oBusy;
    assign oSclk = selB ? ifB.lcd_sclk : ifA.lcd_sclk;
    assign oMosi = selB ? ifB.lcd_mosi : ifA.lcd_mosi;
    assign oDc   = selB ? ifB.lcd_dc   : ifA.lcd_dc;
    assign oCsN  = selB ? ifB.lcd_cs_n : ifA.lcd_cs_n;
    assign oWr   = selB ? ifB.wr_done  : ifA.wr_done;
    assign oBusy = selB ? ifB.busy     : ifA.busy;

    typedef struct {
        int         e0;
        int         w;
        int         firstRise;
        logic [7:0] bits;
        int         rises;
        logic       dc;
        int         dcChanges;
        int         spacingBad;
        int         csHighRun;
        int         prevW;
    } rec_t;

    rec_t recQ[$];
    rec_t cur;
    logic prevCs = 1'b1, prevSclk = 1'b0, prevWr = 1'b0, prevMosi = 1'b0;
    int   lastRise = -1, lastW = 0, csHighCnt = 0, mosiBad = 0, wrLong = 0;

    // Frame decoder: a frame opens on CS falling and closes on wr_done.
    always @(negedge sysClk) begin
        if (sysRst) begin
            prevCs   = 1'b1;
            prevSclk = 1'b0;
            prevWr   = 1'b0;
            prevMosi = 1'b0;
        end else begin
            if (prevCs && !oCsN) begin
                cur.e0         = cyc;
                cur.bits       = '0;
                cur.rises      = 0;
                cur.firstRise  = -1;
                cur.dc         = oDc;
                cur.dcChanges  = 0;
                cur.spacingBad = 0;
                cur.csHighRun  = csHighCnt;
                cur.prevW      = lastW;
                lastRise       = -1;
            end
            if (!oCsN) begin
                if (!prevSclk && oSclk) begin
                    cur.bits  = {cur.bits[6:0], oMosi};
                    cur.rises = cur.rises + 1;
                    if (lastRise < 0) cur.firstRise = cyc;
                    else if (cyc - lastRise != 2 * curDiv) cur.spacingBad++;
                    lastRise = cyc;
                end
                if (oDc !== cur.dc) cur.dcChanges++;
                if (prevSclk && oSclk && oMosi !== prevMosi) mosiBad++;
            end
            if (oWr) begin
                cur.w = cyc;
                if (prevWr) wrLong++;
                else recQ.push_back(cur);
                lastW = cyc;
            end
            csHighCnt = oCsN ? csHighCnt + 1 : 0;
            prevCs    = oCsN;
            prevSclk  = oSclk;
            prevWr    = oWr;
            prevMosi  = oMosi;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300 && oBusy !== 1'b0; i++) begin
            @(posedge sysClk); #1;
        end
        checkOutput("idleReached", oBusy, 0);
    endtask

    task automatic waitRecord(output rec_t r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && recQ.size() == 0; i++) begin
            @(posedge sysClk); #1;
        end
        checkOutput("recordArrived", (recQ.size() > 0), 1);
        if (recQ.size() > 0) begin
            r  = recQ.pop_front();
            ok = 1'b1;
        end
    endtask

    // Expected frame derived from the word and the timing formulas alone.
    task automatic checkRecord(input rec_t r, input logic [8:0] word, input bit checkGap);
        checkOutput("byte", r.bits, word[7:0]);
        checkOutput("dc", r.dc, word[8]);
        checkOutput("sclkRises", r.rises, 8);
        checkOutput("wrDoneAt", r.w - r.e0, 16 * curDiv);
        checkOutput("firstRise", r.firstRise - r.e0, curDiv);
        checkOutput("sclkPeriod", r.spacingBad, 0);
        checkOutput("dcStable", r.dcChanges, 0);
        if (checkGap) begin
            checkOutput("nextSample", r.e0 - r.prevW, curGap + 2);
            checkOutput("csHighGap", (r.csHighRun >= curGap + 1), 1);
        end
    endtask

    // mode 0: one-cycle request; 1: disturb en/data at E0+10; 2: reset at E0+12
    task automatic applyStimulus(input logic [8:0] word, input int mode);
        rec_t r;
        bit   ok;
        waitIdle();
        en     = 1'b1;
        dataIn = word;
        @(posedge sysClk); #1;
        checkOutput("csLowAtE0", oCsN, 0);
        checkOutput("mosiAtE0", oMosi, word[7]);
        if (mode != 1) en = 1'b0;
        if (mode == 1) begin
            repeat (9) @(posedge sysClk);
            #1;
            en     = 1'b0;
            dataIn = ~word;
        end
        if (mode == 2) begin
            repeat (11) @(posedge sysClk);
            #1;
            sysRst = 1'b1;
            @(posedge sysClk); #1;
            checkOutput("rstCsN", oCsN, 1);
            checkOutput("rstSclk", oSclk, 0);
            checkOutput("rstMosi", oMosi, 0);
            checkOutput("rstBusy", oBusy, 0);
            checkOutput("rstDc", oDc, 0);
            checkOutput("rstWrDone", oWr, 0);
            sysRst = 1'b0;
            repeat (60) @(posedge sysClk);
            #1;
            checkOutput("noWrAfterReset", recQ.size(), 0);
        end else begin
            waitRecord(r, ok);
            if (ok) checkRecord(r, word, 1'b0);
        end
    endtask

    task automatic applyBurst(input logic [8:0] words[$], input int adv);
        rec_t r;
        int   idx = 0;
        int   advCnt = 0;
        int   n = words.size();
        waitIdle();
        en     = 1'b1;
        dataIn = words[0];
        for (int i = 0; i < 3000 && idx < n; i++) begin
            @(posedge sysClk); #1;
            if (advCnt > 0) begin
                advCnt--;
                if (advCnt == 0) begin
                    idx++;
                    if (idx < n) dataIn = words[idx];
                    else en = 1'b0;
                end
            end
            if (oWr) advCnt = adv;
        end
        en = 1'b0;
        checkOutput("burstCount", recQ.size(), n);
        for (int i = 0; i < n && recQ.size() > 0; i++) begin
            r = recQ.pop_front();
            checkRecord(r, words[i], i > 0);
        end
        recQ.delete();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [8:0] seqA[$];
        logic [8:0] seqB[$];
        sysRst = 1'b1;
        en     = 1'b0;
        dataIn = '0;
        selB   = 1'b0;
        curDiv = 2;
        curGap = 3;
        repeat (3) @(posedge sysClk);
        #1;
        checkOutput("resetCsN", oCsN, 1);
        checkOutput("resetSclk", oSclk, 0);
        checkOutput("resetMosi", oMosi, 0);
        checkOutput("resetDc", oDc, 0);
        checkOutput("resetBusy", oBusy, 0);
        checkOutput("resetWrDone", oWr, 0);
        sysRst = 1'b0;

        applyStimulus(9'h02A, 0);
        applyStimulus(9'h1A5, 0);
        for (int i = 0; i < 6; i++) applyStimulus(9'($urandom_range(0, 511)), 0);

        seqA = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10F, 9'h02B,
                 9'h100, 9'h114, 9'h100, 9'h123, 9'h02C};
        applyBurst(seqA, 3);

        applyStimulus(9'($urandom_range(0, 511)), 1);
        applyStimulus(9'($urandom_range(0, 511)), 2);
        applyStimulus(9'($urandom_range(0, 511)), 0);

        waitIdle();
        selB   = 1'b1;
        curDiv = 1;
        curGap = 1;
        repeat (2) @(posedge sysClk);
        #1;
        for (int i = 0; i < 4; i++) applyStimulus(9'($urandom_range(0, 511)), 0);
        for (int i = 0; i < 5; i++) seqB.push_back(9'($urandom_range(0, 511)));
        applyBurst(seqB, 1);
        applyStimulus(9'($urandom_range(0, 511)), 2);
        applyStimulus(9'($urandom_range(0, 511)), 0);

        checkOutput("mosiStableWhileHigh", mosiBad, 0);
        checkOutput("wrDonePulseLen", wrLong, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
